// File: rtl/vga_ctrl_pkg.sv
// Shared constants, mode encodings and the display-state payload for the
// VGA mode controller.
//   mode_e      : display modes BARS(0), SOLID(1), BOX(2); 3 is illegal
//   disp_t      : {mode, pos_x, pos_y, color, box_visible} payload
//   DISP_RESET  : value of both shadow and committed state after reset
//   move_axis() : one saturating STEP move along a single axis
package vga_ctrl_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned BOX_SIZE = 32;
  localparam int unsigned X_MAX    = H_ACTIVE - BOX_SIZE;
  localparam int unsigned Y_MAX    = V_ACTIVE - BOX_SIZE;
  localparam int unsigned X_RESET  = X_MAX / 2;
  localparam int unsigned Y_RESET  = Y_MAX / 2;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned MODE_W  = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BARS  = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_BOX   = 2'd2
  } mode_e;

  typedef struct packed {
    mode_e              mode;
    logic [POS_W-1:0]   pos_x;
    logic [POS_W-1:0]   pos_y;
    logic [COLOR_W-1:0] color;
    logic               box_visible;
  } disp_t;

  localparam disp_t DISP_RESET = '{
    mode:        MODE_BARS,
    pos_x:       POS_W'(X_RESET),
    pos_y:       POS_W'(Y_RESET),
    color:       COLOR_W'(0),
    box_visible: 1'b1
  };

  // inc and dec together cancel; moves saturate at 0 and lim instead of wrapping.
  function automatic logic [POS_W-1:0] move_axis(
    input logic [POS_W-1:0] cur,
    input logic             inc,
    input logic             dec,
    input logic [POS_W-1:0] step,
    input logic [POS_W-1:0] lim
  );
    logic [POS_W:0] sum;
    move_axis = cur;
    sum       = {1'b0, cur} + {1'b0, step};
    if (inc && !dec) begin
      move_axis = (sum > {1'b0, lim}) ? lim : sum[POS_W-1:0];
    end else if (dec && !inc) begin
      move_axis = (cur < step) ? POS_W'(0) : cur - step;
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter and press pulse.
//   clk, rst : clock and synchronous active-high reset
//   btn_raw  : asynchronous active-high button
//   press    : one-cycle pulse when the debounced level rises
// A press is only reported once the button has been seen released since
// reset, so a button held through reset does not fire when it settles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [1:0]       fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;

  // Counter runs while the synchronized input disagrees with the debounced
  // level; any agreeing cycle clears it.
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    fill_d  = {fill_q[0], 1'b1};
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    // fill_q[1] marks that sync_q[1] holds a real post-reset sample
    armed_d = armed_q | (fill_q[1] & ~sync_q[1]);
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        press_d = sync_q[1] & armed_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/vga_mode_ctrl.sv
// VGA mode controller: debounced buttons drive a shadow display state
// (mode FSM, box position, colour, blink) that is committed to the outputs
// only on frame_start, so the picture never changes mid-frame.
//   sysclk, rst              : clock, synchronous active-high reset
//   East/West/North/South    : raw direction buttons (move box in BOX mode)
//   func_switch              : raw mode button (BARS -> SOLID -> BOX -> BARS)
//   SW0..SW2, SW3            : raw colour {R,G,B} switches, blink enable
//   frame_start              : vertical blanking pulse, commits shadow state
//   mode/pos_x/pos_y/color/box_visible : committed display state
module vga_mode_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned STEP            = 8,
  parameter int unsigned BLINK_FRAMES    = 32
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               East,
  input  logic               West,
  input  logic               North,
  input  logic               South,
  input  logic               func_switch,
  input  logic               SW0,
  input  logic               SW1,
  input  logic               SW2,
  input  logic               SW3,
  input  logic               frame_start,
  output logic [MODE_W-1:0]  mode,
  output logic [POS_W-1:0]   pos_x,
  output logic [POS_W-1:0]   pos_y,
  output logic [COLOR_W-1:0] color,
  output logic               box_visible
);

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned BTN_E   = 0;
  localparam int unsigned BTN_W   = 1;
  localparam int unsigned BTN_N   = 2;
  localparam int unsigned BTN_S   = 3;
  localparam int unsigned BTN_F   = 4;

  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [POS_W-1:0] STEP_V   = POS_W'(STEP);
  localparam logic [POS_W-1:0] X_LIM    = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] Y_LIM    = POS_W'(Y_MAX);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  logic [3:0]       sw_meta_q, sw_meta_d;
  logic [3:0]       sw_sync_q, sw_sync_d;
  logic [BLK_W-1:0] frame_cnt_q, frame_cnt_d;
  disp_t            shadow_q, shadow_d;
  disp_t            out_q, out_d;

  assign btn_raw = {func_switch, South, North, West, East};

  // One conditioner per button.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (sysclk),
      .rst    (rst),
      .btn_raw(btn_raw[i]),
      .press  (press[i])
    );
  end

  // Next shadow state (mode FSM, position, colour, blink) and commit logic.
  always_comb begin
    sw_meta_d   = {SW3, SW2, SW1, SW0};
    sw_sync_d   = sw_meta_q;
    frame_cnt_d = frame_cnt_q;
    shadow_d    = shadow_q;
    // Commit uses the pre-edge shadow: same-cycle events land next frame.
    out_d       = frame_start ? shadow_q : out_q;

    case (shadow_q.mode)
      MODE_BARS:  if (press[BTN_F]) shadow_d.mode = MODE_SOLID;
      MODE_SOLID: if (press[BTN_F]) shadow_d.mode = MODE_BOX;
      MODE_BOX:   if (press[BTN_F]) shadow_d.mode = MODE_BARS;
      default:    shadow_d.mode = MODE_BARS;
    endcase

    if (shadow_q.mode == MODE_BOX) begin
      shadow_d.pos_x = move_axis(shadow_q.pos_x, press[BTN_E], press[BTN_W], STEP_V, X_LIM);
      shadow_d.pos_y = move_axis(shadow_q.pos_y, press[BTN_S], press[BTN_N], STEP_V, Y_LIM);
    end

    shadow_d.color = sw_sync_q[2:0];

    // Blink: toggle every BLINK_FRAMES frames; disabled means always shown.
    if (sw_sync_q[3]) begin
      if (frame_start) begin
        if (frame_cnt_q == BLK_LAST) begin
          frame_cnt_d          = '0;
          shadow_d.box_visible = ~shadow_q.box_visible;
        end else begin
          frame_cnt_d = frame_cnt_q + BLK_W'(1);
        end
      end
    end else begin
      frame_cnt_d          = '0;
      shadow_d.box_visible = 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      frame_cnt_q <= '0;
      shadow_q    <= DISP_RESET;
      out_q       <= DISP_RESET;
    end else begin
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      frame_cnt_q <= frame_cnt_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
    end
  end

  assign mode        = out_q.mode;
  assign pos_x       = out_q.pos_x;
  assign pos_y       = out_q.pos_y;
  assign color       = out_q.color;
  assign box_visible = out_q.box_visible;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Scoreboard bench for vga_mode_ctrl: each reset or frame_start pushes the
// expected committed state; a monitor pops and compares after that edge.
module tb_vga_mode_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned STP = 8;
  localparam int unsigned BLK = 2;

  localparam logic [4:0] B_E = 5'b00001;
  localparam logic [4:0] B_W = 5'b00010;
  localparam logic [4:0] B_N = 5'b00100;
  localparam logic [4:0] B_S = 5'b01000;
  localparam logic [4:0] B_F = 5'b10000;

  typedef struct packed {
    logic [1:0] m;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] c;
    logic       v;
  } exp_t;

  logic       sysclk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic [3:0] sw;
  logic       frame_start;
  logic [1:0] mode;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [2:0] color;
  logic       box_visible;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   ev_no = 0;
  logic ev_seen;

  always #5 sysclk = ~sysclk;

  vga_mode_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .STEP           (STP),
    .BLINK_FRAMES   (BLK)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .East       (btn[0]),
    .West       (btn[1]),
    .North      (btn[2]),
    .South      (btn[3]),
    .func_switch(btn[4]),
    .SW0        (sw[0]),
    .SW1        (sw[1]),
    .SW2        (sw[2]),
    .SW3        (sw[3]),
    .frame_start(frame_start),
    .mode       (mode),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .color      (color),
    .box_visible(box_visible)
  );

  function automatic exp_t mk(int m, int x, int y, int c, int v);
    exp_t e;
    e.m = 2'(m);
    e.x = 10'(x);
    e.y = 10'(y);
    e.c = 3'(c);
    e.v = 1'(v);
    return e;
  endfunction

  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: outputs may only change at a reset or frame_start edge.
  always @(posedge sysclk) ev_seen <= frame_start | rst;

  initial begin
    exp_t e;
    forever begin
      @(negedge sysclk);
      if (ev_seen === 1'b1) begin
        ev_no++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event #%0d: got update expected none", ev_no);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("ev%0d.mode", ev_no), int'(mode), int'(e.m));
          chk($sformatf("ev%0d.pos_x", ev_no), int'(pos_x), int'(e.x));
          chk($sformatf("ev%0d.pos_y", ev_no), int'(pos_y), int'(e.y));
          chk($sformatf("ev%0d.color", ev_no), int'(color), int'(e.c));
          chk($sformatf("ev%0d.box_visible", ev_no), int'(box_visible), int'(e.v));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.push_back(mk(0, 304, 224, 0, 1));
    @(negedge sysclk);
    rst = 1'b0;
    tick(4);
  endtask

  task automatic frame(exp_t e);
    frame_start = 1'b1;
    exp_q.push_back(e);
    @(negedge sysclk);
    frame_start = 1'b0;
    tick(3);
  endtask

  task automatic press(logic [4:0] m);
    btn = btn | m;
    tick(DEB + 6);
    btn = btn & ~m;
    tick(DEB + 6);
  endtask

  initial begin
    btn         = '0;
    sw          = '0;
    frame_start = 1'b0;
    do_reset();

    // Reset state committed by the first frame
    frame(mk(0, 304, 224, 0, 1));

    // Short glitch on func_switch is rejected
    btn[4] = 1'b1;
    tick(2);
    btn[4] = 1'b0;
    tick(8);
    frame(mk(0, 304, 224, 0, 1));

    // Mode cycles BARS -> SOLID -> BOX -> BARS
    press(B_F); frame(mk(1, 304, 224, 0, 1));
    press(B_F); frame(mk(2, 304, 224, 0, 1));
    press(B_F); frame(mk(0, 304, 224, 0, 1));

    // Direction press outside BOX is discarded
    press(B_W); frame(mk(0, 304, 224, 0, 1));

    // East 39 times from 304 saturates at 608
    press(B_F); press(B_F);
    frame(mk(2, 304, 224, 0, 1));
    repeat (39) press(B_E);
    frame(mk(2, 608, 224, 0, 1));

    // Opposing N+S cancel while East still moves
    do_reset();
    press(B_F); press(B_F);
    press(B_N | B_S | B_E);
    frame(mk(2, 312, 224, 0, 1));

    // North 30 times from 224 saturates at 0
    repeat (30) press(B_N);
    frame(mk(2, 312, 0, 0, 1));

    // Colour 7 with blink: visibility 1,1,0,0,1,1
    sw = 4'hF;
    tick(4);
    frame(mk(2, 312, 0, 7, 1));
    frame(mk(2, 312, 0, 7, 1));
    frame(mk(2, 312, 0, 7, 0));
    frame(mk(2, 312, 0, 7, 0));
    frame(mk(2, 312, 0, 7, 1));
    frame(mk(2, 312, 0, 7, 1));
    sw = 4'h0;
    tick(4);
    frame(mk(2, 312, 0, 0, 1));

    // Reset mid-debounce of a held East; no move until re-pressed
    btn[0] = 1'b1;
    tick(4);
    do_reset();
    press(B_F); press(B_F);
    tick(6);
    frame(mk(2, 304, 224, 0, 1));
    btn[0] = 1'b0;
    tick(DEB + 6);
    press(B_E);
    frame(mk(2, 312, 224, 0, 1));

    tick(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_mode_ctrl.md
VGA_MODE_CTRL -- requirements
Module: vga_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a button level (10 ms at 50 MHz).
REQ-002 Parameter STEP, default 8, pixels moved per direction press.
REQ-003 Parameter BLINK_FRAMES, default 32, frames per box blink half-period.
REQ-004 sysclk  in  1  single 50 MHz clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 East, West, North, South  in  1 each  raw direction buttons, asynchronous, active-high.
REQ-007 func_switch  in  1  raw mode button, asynchronous, active-high.
REQ-008 SW0, SW1, SW2, SW3  in  1 each  raw slide switches; SW2..SW0 = colour {R,G,B}, SW3 = blink enable.
REQ-009 frame_start  in  1  one-cycle pulse from the VGA timing generator at start of vertical blanking.
REQ-010 mode  out  2  committed display mode.
REQ-011 pos_x  out  10  committed box left edge, pixels.
REQ-012 pos_y  out  10  committed box top edge, pixels.
REQ-013 color  out  3  committed {R,G,B} colour.
REQ-014 box_visible  out  1  committed box visibility.

Function
REQ-015 Each of the 9 raw inputs SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 Each button SHALL change its debounced level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-017 A press event SHALL be a one-cycle pulse on the debounced 0->1 edge; releases generate no event.
REQ-018 The mode FSM SHALL have states BARS(0), SOLID(1), BOX(2) and advance BARS->SOLID->BOX->BARS on each func_switch press; encoding 3 is unreachable and SHALL recover to BARS.
REQ-019 Direction presses SHALL update shadow position only in state BOX; in other states they are discarded.
REQ-020 East adds STEP to shadow_x, West subtracts, South adds STEP to shadow_y, North subtracts.
REQ-021 Shadow_x SHALL clamp to 0..608 (640-32) and shadow_y to 0..448 (480-32); a move past a bound saturates at the bound, no wrap.
REQ-022 East and West pressed in the same cycle SHALL leave shadow_x unchanged; likewise North and South for shadow_y; the orthogonal axis still updates.
REQ-023 Shadow color SHALL track synchronized {SW2,SW1,SW0} each cycle; switches are not debounced.
REQ-024 A frame counter SHALL count frame_start pulses; when synchronized SW3=1 the shadow visibility toggles every BLINK_FRAMES frames; when SW3=0 shadow visibility is 1 and counter is held at 0.
REQ-025 On frame_start, all outputs SHALL load their shadow values at that edge; outputs SHALL NOT change at any other time except reset.
REQ-026 An event in the same cycle as frame_start SHALL update shadow only; it appears at the following frame_start.
REQ-027 Latency: stable press to shadow update = 2 + DEBOUNCE_CYCLES + 1 cycles; shadow to output = next frame_start.

Reset
REQ-028 While rst=1 at a clock edge: mode=BARS, pos_x=304, pos_y=224, color=0, box_visible=1, shadow registers equal to these, debounced levels=0, debounce and frame counters=0, synchronizers=0.
REQ-029 Reset mid-debounce or mid-frame SHALL discard pending events and shadow changes; no event fires on the first cycle after reset even if a button is held.

Structure
REQ-030 Package vga_ctrl_pkg SHALL hold mode encodings, H_ACTIVE=640, V_ACTIVE=480, BOX_SIZE=32, and derived X_MAX, Y_MAX, X_RESET, Y_RESET.
REQ-031 Sub-module btn_debounce (synchronizer + counter + edge pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated five times.

Verification (DEBOUNCE_CYCLES=4, STEP=8, BLINK_FRAMES=2)
REQ-032 Reset, then one frame_start -> mode=0, pos_x=304, pos_y=224, color=0, box_visible=1.
REQ-033 func_switch pulsed high 2 cycles, then held 8 cycles -> no event; three clean presses with frame_start -> mode 1, 2, then 0.
REQ-034 In BOX, East pressed 39 times, frame_start -> pos_x=608; West pressed in BARS -> shadow unchanged.
REQ-035 In BOX, North and South held together, East held, frame_start -> pos_y=224, pos_x=312.
REQ-036 SW0..SW3=1, six frame_start pulses -> color=7, box_visible sequence 1,1,0,0,1,1 from the first frame.
REQ-037 rst asserted 1 cycle mid-debounce of a held East -> outputs at reset values, no move until East released and re-pressed.
